// File: rtl/rsa_key_unwrap.sv
// rsa_key_unwrap
// Recovers a wrapped key with RSA decryption: key_out = (c^d mod n)[W-1:0].
// Exponentiation is left-to-right square-and-multiply. Each modular product
// is computed by an interleaved, bit-serial multiplier that takes 2W cycles.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : request pulse, sampled only while idle
//   n       : modulus (2W bits)
//   d       : private exponent (2W bits)
//   c       : ciphertext / wrapped key (2W bits)
//   key_out : recovered key, low W bits of c^d mod n
//   busy    : high from the cycle after a start is accepted until done
//   done    : one-cycle pulse when key_out/err are valid
//   err     : operand error (n<2 or c>=n), valid with done
module rsa_key_unwrap #(
  parameter int W = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] n,
  input  logic [2*W-1:0] d,
  input  logic [2*W-1:0] c,
  output logic [W-1:0]   key_out,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int NW = 2 * W;
  localparam int CW = $clog2(NW);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SQR, S_MUL, S_NEXT, S_FIN
  } state_t;

  state_t r_state, w_state_next;

  logic [NW-1:0] r_n, r_d, r_c;
  logic [NW-1:0] r_r;       // exponentiation accumulator
  logic [NW-1:0] r_t;       // multiplier partial product
  logic [CW-1:0] r_cnt;     // multiplier bit position (MSB first)
  logic [CW-1:0] r_idx;     // exponent bit index
  logic [W-1:0]  r_key_out;
  logic          r_busy, r_done, r_err;

  // One interleaved multiply step. Both operands are < n, so the doubled
  // value and the sum each stay below 2n and one conditional subtraction
  // brings them back into [0, n). The extra top bit keeps the carry.
  logic [NW:0]   w_dbl, w_dbl_red, w_add, w_add_red, w_n_ext;
  logic [NW-1:0] w_y, w_t_next;
  logic          w_xbit, w_last, w_bad;

  always_comb begin
    w_n_ext   = {1'b0, r_n};
    w_y       = (r_state == S_MUL) ? r_c : r_r;
    w_xbit    = r_r[r_cnt];
    w_dbl     = {r_t, 1'b0};
    w_dbl_red = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
    w_add     = w_dbl_red + {1'b0, w_y};
    w_add_red = (w_add >= w_n_ext) ? (w_add - w_n_ext) : w_add;
    w_t_next  = w_xbit ? w_add_red[NW-1:0] : w_dbl_red[NW-1:0];
    w_last    = (r_cnt == '0);
    w_bad     = (r_n < NW'(2)) || (r_c >= r_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The NEXT decision is folded into the last cycle of SQR/MUL, so the
  // NEXT encoding is never resident; it only falls through defensively.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_CHECK;
      S_CHECK: w_state_next = w_bad ? S_FIN : S_SQR;
      S_SQR: begin
        if (w_last) begin
          if (r_d[r_idx])        w_state_next = S_MUL;
          else if (r_idx == '0)  w_state_next = S_FIN;
          else                   w_state_next = S_SQR;
        end
      end
      S_MUL: begin
        if (w_last) w_state_next = (r_idx == '0) ? S_FIN : S_SQR;
      end
      S_NEXT:  w_state_next = (r_idx == '0) ? S_FIN : S_SQR;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n       <= '0;
      r_d       <= '0;
      r_c       <= '0;
      r_r       <= '0;
      r_t       <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_key_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n    <= n;
            r_d    <= d;
            r_c    <= c;
            r_busy <= 1'b1;
          end
        end
        S_CHECK: begin
          r_key_out <= '0;
          r_err     <= w_bad;
          r_r       <= NW'(1);
          r_t       <= '0;
          r_idx     <= CW'(NW - 1);
          r_cnt     <= CW'(NW - 1);
        end
        S_SQR, S_MUL: begin
          if (w_last) begin
            r_r   <= w_t_next;
            r_t   <= '0;
            r_cnt <= CW'(NW - 1);
            // Step to the next exponent bit unless a MUL still follows.
            if (r_idx != '0 && (r_state == S_MUL || !r_d[r_idx]))
              r_idx <= r_idx - 1'b1;
          end else begin
            r_t   <= w_t_next;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_NEXT: begin
          if (r_idx != '0) r_idx <= r_idx - 1'b1;
        end
        S_FIN: begin
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_key_out <= r_err ? '0 : r_r[W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign key_out = r_key_out;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_rsa_key_unwrap.sv
// Testbench for rsa_key_unwrap (W=8). Stimulus pushes the hand-computed
// expected response onto a queue; a monitor pops it whenever done pulses.
module tb_rsa_key_unwrap;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   n = '0, d = '0, c = '0;
  logic [W-1:0]  key_out;
  logic          busy, done, err;

  rsa_key_unwrap #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .d(d), .c(c),
    .key_out(key_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   dones = 0;
  int   dones_exp = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops and compares on every done pulse.
  initial forever begin
    @(posedge clk);
    #1;
    if (done) begin
      exp_t e;
      dones++;
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("key_out", int'(key_out), int'(e.key));
        chk("err", int'(err), int'(e.err));
        chk("latency", cyc - e.acc, e.lat);
        chk("busy_at_done", int'(busy), 0);
        $display("txn done: key_out=%0d err=%0d latency=%0d", key_out, err, cyc - e.acc);
      end
    end
  end

  task automatic issue(input logic [15:0] nn, dd, cc,
                       input logic [7:0] key, input logic e, input int lat);
    exp_t x;
    @(negedge clk);
    n = nn; d = dd; c = cc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x.key = key; x.err = e; x.lat = lat; x.acc = cyc;
    q.push_back(x);
    dones_exp++;
    chk("busy_after_accept", int'(busy), 1);
    // Latched operands must be immune to later input changes.
    n = 16'($urandom); d = 16'($urandom); c = 16'($urandom);
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 1000 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
  endtask

  task automatic check_hold(input logic [7:0] key, input logic e);
    repeat (3) @(negedge clk);
    chk("hold_key", int'(key_out), int'(key));
    chk("hold_err", int'(err), int'(e));
  endtask

  initial begin
    #2;
    chk("rst_key", int'(key_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Decrypt: 2790^2753 mod 3233 = 65
    issue(16'd3233, 16'd2753, 16'd2790, 8'd65, 1'b0, 338);
    wait_empty();
    check_hold(8'd65, 1'b0);

    // Encrypt direction: 65^17 mod 3233 = 2790 = 0xAE6
    issue(16'd3233, 16'd17, 16'd65, 8'hE6, 1'b0, 290);
    wait_empty();

    // c >= n and n < 2 error paths
    issue(16'd3233, 16'd17, 16'd3233, 8'd0, 1'b1, 2);
    wait_empty();
    check_hold(8'd0, 1'b1);
    issue(16'd1, 16'd17, 16'd0, 8'd0, 1'b1, 2);
    wait_empty();

    // d = 0 with a start re-pulsed while busy (ignored)
    issue(16'd3233, 16'd0, 16'd2790, 8'd1, 1'b0, 258);
    repeat (50) @(negedge clk);
    n = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (5) @(negedge clk);

    // c = 0, d != 0
    issue(16'd3233, 16'd17, 16'd0, 8'd0, 1'b0, 290);
    wait_empty();

    // 10^2 mod 3233 = 100, popcount(d) = 1
    issue(16'd3233, 16'd2, 16'd10, 8'd100, 1'b0, 274);
    wait_empty();

    // Even modulus: 7^3 mod 100 = 43
    issue(16'd100, 16'd3, 16'd7, 8'd43, 1'b0, 290);
    wait_empty();

    // Reset mid-operation aborts with no done
    issue(16'd3233, 16'd2753, 16'd2790, 8'd65, 1'b0, 338);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    q.delete();
    dones_exp--;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_key", int'(key_out), 0);
    chk("abort_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);

    // Restart after abort
    issue(16'd3233, 16'd2753, 16'd2790, 8'd65, 1'b0, 338);
    wait_empty();

    repeat (5) @(negedge clk);
    chk("done_count", dones, dones_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
